// File: rtl/dm_cache_pkg.sv
// Shared types for the direct-mapped L1 cache: FSM states, line type and
// the helper that turns a word write into byte-lane enables within a line.
package cache_types;

  localparam int S_OFFSET = 5;
  localparam int LINE_W   = 256;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    WB,
    FILL
  } cache_state_t;

  typedef logic [LINE_W-1:0] cache_line_t;

  // Place a 4-bit word byte-enable at its byte position inside a 32-byte line.
  function automatic logic [31:0] word_mask(input logic [2:0] word, input logic [3:0] be);
    return {28'b0, be} << {word, 2'b00};
  endfunction

endpackage

// File: rtl/dm_cache_if.sv
// Bundle of the core-side word interface and the line-granular physical
// memory interface seen by the cache.
interface dm_cache_if;
  import cache_types::*;

  // Handshakes: the core holds mem_read/mem_write and operands until a single
  // mem_resp pulse; the cache holds pmem_read/pmem_write, pmem_address and
  // pmem_wdata stable until a single pmem_resp pulse. One outstanding request
  // on each side, and pmem_read/pmem_write are never both high.
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  cache_line_t pmem_wdata;
  cache_line_t pmem_rdata;
  logic        pmem_resp;

  // Driven by the core and physical memory (or a testbench standing in for them).
  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

  // The cache itself.
  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

endinterface

// File: rtl/dm_cache_data_array.sv
// Line storage for the cache: byte-maskable synchronous write, combinational read.
module cache_data_array
  import cache_types::*;
#(
  parameter int S_INDEX = 3
) (
  input  logic               clk,
  input  logic [S_INDEX-1:0] index,
  input  logic [31:0]        we_mask,
  input  cache_line_t        wdata,
  output cache_line_t        rdata
);

  cache_line_t mem [2**S_INDEX];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 32; b++) begin
      if (we_mask[b]) mem[index][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/dm_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache between the core's word
// interface and 256-bit line memory. Tag/valid/dirty live here; lines in cache_data_array.
module dm_cache
  import cache_types::*;
#(
  parameter int S_INDEX = 3
) (
  input  logic         clk,
  input  logic         rst,
  dm_cache_if.slave    bus,
  output cache_state_t dbg_state
);

  localparam int S_TAG = 32 - S_OFFSET - S_INDEX;
  localparam int SETS  = 2 ** S_INDEX;

  cache_state_t state, state_next;

  logic [31:2]        req_addr;
  logic [31:0]        req_wdata;
  logic [3:0]         req_be;
  logic               req_write;

  logic [SETS-1:0]    valid;
  logic [SETS-1:0]    dirty;
  logic [S_TAG-1:0]   tag_arr [SETS];

  logic [S_TAG-1:0]   req_tag;
  logic [S_INDEX-1:0] req_idx;
  logic [2:0]         req_word;
  logic               hit;

  cache_line_t        line;
  cache_line_t        da_wdata;
  logic [31:0]        we_mask;

  logic               mem_resp;
  logic               pmem_read;
  logic               pmem_write;
  logic [31:0]        pmem_address;

  // Byte offset within a word is meaningless to a word-granular cache.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.mem_address[1:0];

  assign req_tag  = req_addr[31:S_OFFSET+S_INDEX];
  assign req_idx  = req_addr[S_OFFSET+S_INDEX-1:S_OFFSET];
  assign req_word = req_addr[4:2];
  assign hit      = valid[req_idx] && (tag_arr[req_idx] == req_tag);

  cache_data_array #(.S_INDEX(S_INDEX)) u_data (
    .clk     (clk),
    .index   (req_idx),
    .we_mask (we_mask),
    .wdata   (da_wdata),
    .rdata   (line)
  );

  always_comb begin
    state_next   = state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    we_mask      = '0;
    da_wdata     = '0;
    unique case (state)
      IDLE: begin
        if (bus.mem_read || bus.mem_write) state_next = CHECK;
      end
      CHECK: begin
        if (hit) begin
          mem_resp   = 1'b1;
          state_next = IDLE;
          if (req_write) begin
            we_mask  = word_mask(req_word, req_be);
            da_wdata = {8{req_wdata}};
          end
        end else if (valid[req_idx] && dirty[req_idx]) begin
          state_next = WB;
        end else begin
          state_next = FILL;
        end
      end
      WB: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_arr[req_idx], req_idx, {S_OFFSET{1'b0}}};
        if (bus.pmem_resp) state_next = FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, req_idx, {S_OFFSET{1'b0}}};
        if (bus.pmem_resp) begin
          we_mask    = '1;
          da_wdata   = bus.pmem_rdata;
          state_next = CHECK;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      valid     <= '0;
      dirty     <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_be    <= '0;
      req_write <= 1'b0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (bus.mem_read || bus.mem_write) begin
            req_addr  <= bus.mem_address[31:2];
            req_wdata <= bus.mem_wdata;
            req_be    <= bus.mem_byte_enable;
            req_write <= bus.mem_write;
          end
        end
        CHECK: begin
          if (hit && req_write && (req_be != 4'b0)) dirty[req_idx] <= 1'b1;
        end
        WB: begin
          if (bus.pmem_resp) dirty[req_idx] <= 1'b0;
        end
        FILL: begin
          if (bus.pmem_resp) begin
            valid[req_idx] <= 1'b1;
            dirty[req_idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tags are deliberately not reset; valid[] alone gates their use.
  always_ff @(posedge clk) begin
    if (state == FILL && bus.pmem_resp) tag_arr[req_idx] <= req_tag;
  end

  assign bus.mem_resp     = mem_resp;
  assign bus.mem_rdata    = line[{req_word, 5'b00000} +: 32];
  assign bus.pmem_read    = pmem_read;
  assign bus.pmem_write   = pmem_write;
  assign bus.pmem_address = pmem_address;
  assign bus.pmem_wdata   = line;
  assign dbg_state        = state;

endmodule

// File: tb/tb_dm_cache.sv
// Directed bench for dm_cache: cold miss, hits, partial write, dirty eviction,
// slow fill, and reset during writeback.
module tb_dm_cache;
  import cache_types::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  cache_state_t dbg_state;
  int           checks   = 0;
  int           failures = 0;

  dm_cache_if bus ();

  dm_cache #(.S_INDEX(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req_start(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
    @(posedge clk);
    #1;
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_address     = addr;
    bus.mem_wdata       = wdata;
    bus.mem_byte_enable = be;
  endtask

  // Expects mem_resp on the next falling edge, then drops the request and
  // confirms the pulse lasted exactly one cycle.
  task automatic expect_resp(input string tag, input logic chk_rdata, input logic [31:0] exp_rdata);
    @(negedge clk);
    check({tag, "_resp"}, bus.mem_resp, 1'b1);
    if (chk_rdata) check({tag, "_rdata"}, bus.mem_rdata, exp_rdata);
    @(posedge clk);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    @(negedge clk);
    check({tag, "_resp_once"}, bus.mem_resp, 1'b0);
    check({tag, "_idle"}, dbg_state, IDLE);
  endtask

  // Request already driven; checks a hit completes one cycle after it is seen.
  task automatic hit_access(input string tag, input logic chk_rdata, input logic [31:0] exp_rdata);
    @(negedge clk);
    check({tag, "_noresp_c0"}, bus.mem_resp, 1'b0);
    check({tag, "_nopmem"}, {bus.pmem_read, bus.pmem_write}, 2'b00);
    expect_resp(tag, chk_rdata, exp_rdata);
  endtask

  // Waits for a physical memory request, checks its kind and address, holds
  // off pmem_resp for `delay` cycles while checking stability, then answers.
  task automatic pmem_serve(input string tag, input logic want_write, input logic [31:0] exp_addr,
                            input int delay, input cache_line_t rline, output cache_line_t wline);
    int n;
    int early;
    logic [31:0] addr0;
    n = 0;
    early = 0;
    @(negedge clk);
    while (!(bus.pmem_read || bus.pmem_write) && n < 50) begin
      if (bus.mem_resp) early++;
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, (n < 50), 1'b1);
    check({tag, "_early_resp"}, early, 0);
    check({tag, "_kind"}, {bus.pmem_write, bus.pmem_read}, {want_write, !want_write});
    check({tag, "_addr"}, bus.pmem_address, exp_addr);
    addr0 = bus.pmem_address;
    wline = bus.pmem_wdata;
    for (int i = 1; i < delay; i++) begin
      @(negedge clk);
      check({tag, "_hold_kind"}, {bus.pmem_write, bus.pmem_read}, {want_write, !want_write});
      check({tag, "_hold_addr"}, bus.pmem_address, addr0);
      check({tag, "_hold_noresp"}, bus.mem_resp, 1'b0);
      if (want_write) check({tag, "_hold_wdata"}, bus.pmem_wdata, wline);
    end
    bus.pmem_rdata = rline;
    bus.pmem_resp  = 1'b1;
    @(posedge clk);
    #1;
    bus.pmem_resp  = 1'b0;
  endtask

  cache_line_t line_a, line_b, line_c, line_a_dirty, wb_line, dummy;
  int          n;

  initial begin
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_address     = '0;
    bus.mem_wdata       = '0;
    bus.mem_byte_enable = '0;
    bus.pmem_rdata      = '0;
    bus.pmem_resp       = 1'b0;

    for (int i = 0; i < 8; i++) begin
      line_a[i*32 +: 32] = 32'h1000_0000 + 32'(i);
      line_b[i*32 +: 32] = 32'h2000_0000 + 32'(i);
      line_c[i*32 +: 32] = 32'h3000_0000 + 32'(i);
    end
    line_a[63:32] = 32'hDEAD_BEEF;
    line_a_dirty  = line_a;
    line_a_dirty[63:32] = 32'hDEAD_5678;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_state", dbg_state, IDLE);
    check("rst_mem_resp", bus.mem_resp, 1'b0);
    check("rst_pmem_rw", {bus.pmem_read, bus.pmem_write}, 2'b00);
    check("rst_pmem_addr", bus.pmem_address, 32'h0);
    rst = 1'b1;

    // Cold read miss, fill returned after 3 cycles
    req_start(1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'h0);
    pmem_serve("cold_fill", 1'b0, 32'h0000_0040, 3, line_a, dummy);
    expect_resp("cold_read", 1'b1, 32'hDEAD_BEEF);

    // Hit read of another word in the same line
    req_start(1'b1, 1'b0, 32'h0000_0048, 32'h0, 4'h0);
    hit_access("hit_read48", 1'b1, 32'h1000_0002);

    // Partial write hit, then read back merged word
    req_start(1'b0, 1'b1, 32'h0000_0044, 32'h1234_5678, 4'b0011);
    hit_access("hit_write44", 1'b0, 32'h0);
    req_start(1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'h0);
    hit_access("hit_read44", 1'b1, 32'hDEAD_5678);

    // Read and write both asserted: write wins
    req_start(1'b1, 1'b1, 32'h0000_0050, 32'hCAFE_F00D, 4'b1111);
    hit_access("both_write50", 1'b0, 32'h0);
    req_start(1'b1, 1'b0, 32'h0000_0050, 32'h0, 4'h0);
    hit_access("both_read50", 1'b1, 32'hCAFE_F00D);
    line_a_dirty[159:128] = 32'hCAFE_F00D;

    // Conflict miss on dirty line: writeback then slow fill (10 cycles)
    req_start(1'b1, 1'b0, 32'h0000_0144, 32'h0, 4'h0);
    pmem_serve("evict_wb", 1'b1, 32'h0000_0040, 2, dummy, wb_line);
    check("evict_wb_word1", wb_line[63:32], 32'hDEAD_5678);
    check("evict_wb_line", wb_line, line_a_dirty);
    pmem_serve("slow_fill", 1'b0, 32'h0000_0140, 10, line_b, dummy);
    expect_resp("evict_read", 1'b1, 32'h2000_0001);

    // Dirty the new line, then force a writeback and reset in the middle of it
    req_start(1'b0, 1'b1, 32'h0000_015C, 32'hA5A5_A5A5, 4'b1111);
    hit_access("dirty_b", 1'b0, 32'h0);
    req_start(1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'h0);
    n = 0;
    @(negedge clk);
    while (!bus.pmem_write && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rstwb_seen", (n < 20), 1'b1);
    check("rstwb_addr", bus.pmem_address, 32'h0000_0140);
    rst = 1'b0;
    #1;
    check("rstwb_pmem_write", bus.pmem_write, 1'b0);
    check("rstwb_pmem_read", bus.pmem_read, 1'b0);
    check("rstwb_resp", bus.mem_resp, 1'b0);
    check("rstwb_state", dbg_state, IDLE);
    bus.mem_read = 1'b0;
    @(negedge clk);
    check("rstwb_hold_resp", bus.mem_resp, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rstwb_post_state", dbg_state, IDLE);

    // All lines invalid after reset: previously cached address misses again
    req_start(1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'h0);
    pmem_serve("post_rst_fill", 1'b0, 32'h0000_0040, 1, line_c, dummy);
    expect_resp("post_rst_read", 1'b1, 32'h3000_0001);

    // Spurious pmem_resp while idle is ignored
    @(posedge clk);
    #1;
    bus.pmem_resp = 1'b1;
    @(posedge clk);
    #1;
    bus.pmem_resp = 1'b0;
    @(negedge clk);
    check("spurious_state", dbg_state, IDLE);
    req_start(1'b1, 1'b0, 32'h0000_0058, 32'h0, 4'h0);
    hit_access("spurious_hit", 1'b1, 32'h3000_0006);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
